// File: rtl/latch_pair_pkg.sv
// Shared types for the latch-pair capture stage: phase encoding, entry layout,
// mismatch counter width and its saturating increment.
package latch_pair_pkg;

  typedef enum logic {
    HELD = 1'b0,
    OPEN = 1'b1
  } phase_t;

  localparam int PAIR_W    = 8;
  localparam int MIS_CNT_W = 8;

  typedef struct packed {
    logic [PAIR_W-1:0] a;
    logic [PAIR_W-1:0] b;
    logic              mis;
  } pair_entry_t;

  function automatic logic [MIS_CNT_W-1:0] sat_inc(input logic [MIS_CNT_W-1:0] v);
    if (v == {MIS_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(MIS_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/latch_pair_fifo.sv
// Synchronous FIFO for captured latch pairs; power-of-two depth, type-parameterized
// entries, head data masked to zero while empty, registered full flag.
module latch_pair_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = latch_pair_pkg::pair_entry_t
) (
  input  logic   clk,
  input  logic   arst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_data,
  output entry_t rd_data,
  output logic   empty,
  output logic   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  entry_t             mem_r [0:DEPTH-1];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_next_s;
  logic               full_r;
  logic               empty_s;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign empty   = empty_s;
  assign full    = full_r;
  assign rd_data = empty_s ? entry_t'({$bits(entry_t){1'b0}}) : mem_r[rd_ptr_r];

  // Qualify requests and derive next occupancy; a push into a full FIFO needs a same-cycle pop
  always_comb begin
    pop_ok_s     = pop & ~empty_s;
    push_ok_s    = push & (~full_r | pop_ok_s);
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointer, occupancy and full-flag registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_FULL);
    end
  end

  // Entry storage; contents are don't-care outside the occupied window
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/latch_pair_capture.sv
// Captures the dual-latch pair when the shared enable closes and streams it out.
// Optional saturating mismatch counter: define LATCH_PAIR_CAPTURE_MISMATCH_CNT_EN.
module latch_pair_capture
  import latch_pair_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic           i_clk,
  input  logic           i_arst,
  input  logic           i_en,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [2*W-1:0] o_data,
  output logic           o_mismatch,
  output logic           o_full,
  output logic           o_overflow
`ifdef LATCH_PAIR_CAPTURE_MISMATCH_CNT_EN
  ,
  output logic [MIS_CNT_W-1:0] o_mis_cnt
`endif
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mis;
  } entry_t;

  phase_t state_r;
  phase_t state_next_s;
  logic   cap_s;
  logic   mis_s;
  logic   pop_s;
  logic   push_s;
  logic   drop_s;
  logic   empty_s;
  logic   full_s;
  logic   overflow_r;
  entry_t wr_entry_s;
  entry_t rd_entry_s;

  // Phase register doubles as the one-cycle delayed enable
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_r <= HELD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next phase follows the enable; the capture strobe is the OPEN->HELD transition
  always_comb begin
    state_next_s = state_r;
    cap_s        = 1'b0;
    case (state_r)
      OPEN: begin
        if (i_en) begin
          state_next_s = OPEN;
        end else begin
          state_next_s = HELD;
          cap_s        = 1'b1;
        end
      end
      HELD: begin
        if (i_en) begin
          state_next_s = OPEN;
        end else begin
          state_next_s = HELD;
        end
      end
      default: begin
        state_next_s = HELD;
        cap_s        = 1'b0;
      end
    endcase
  end

  assign mis_s      = (i_a != i_b);
  assign wr_entry_s = '{a: i_a, b: i_b, mis: mis_s};
  assign pop_s      = ~empty_s & i_ready;
  assign push_s     = cap_s & (~full_s | pop_s);
  assign drop_s     = cap_s & full_s & ~pop_s;

  latch_pair_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (i_clk),
    .arst    (i_arst),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (wr_entry_s),
    .rd_data (rd_entry_s),
    .empty   (empty_s),
    .full    (full_s)
  );

  // Sticky drop flag, cleared only by reset
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

`ifdef LATCH_PAIR_CAPTURE_MISMATCH_CNT_EN
  logic [MIS_CNT_W-1:0] mis_cnt_r;

  // Counts every mismatched capture, whether stored or dropped
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      mis_cnt_r <= {MIS_CNT_W{1'b0}};
    end else if (cap_s && mis_s) begin
      mis_cnt_r <= sat_inc(mis_cnt_r);
    end else begin
      mis_cnt_r <= mis_cnt_r;
    end
  end

  assign o_mis_cnt = mis_cnt_r;
`endif

  assign o_valid    = ~empty_s;
  assign o_data     = {rd_entry_s.a, rd_entry_s.b};
  assign o_mismatch = rd_entry_s.mis;
  assign o_full     = full_s;
  assign o_overflow = overflow_r;

endmodule
